// File: rtl/victim_cache_pkg.sv
// victim_cache_pkg
//   Shared constants for the victim cache: geometry, key width and the
//   positions of the fields packed into page_offset.
//   page_offset layout: [11:6] vindex, [5:3] word select, [2:0] byte select.
package victim_cache_pkg;

    localparam int WAYS     = 8;
    localparam int BLOCK_W  = 512;
    localparam int PTAG_W   = 44;

    localparam int OFFSET_W   = 12;
    localparam int VINDEX_LSB = 6;
    localparam int VINDEX_W   = 6;
    localparam int KEY_W      = PTAG_W + VINDEX_W;

    // Byte offset inside a block: the upper three bits pick a 64-bit word
    // and the lower three bits pick a byte in that word.
    localparam int BLK_OFF_W    = 6;
    localparam int WORD_SEL_LSB = 3;
    localparam int BYTE_SEL_LSB = 0;
    localparam int SEL_W        = 3;
    localparam int WORD_W       = 64;
    localparam int BYTE_W       = 8;

endpackage

// File: rtl/victim_cache_lru.sv
// lru
//   True-LRU tracker built from one age counter per way. Age 0 is the most
//   recently used way, age WAYS-1 the least recently used one.
//   Ports:
//     clk, reset  - clock, asynchronous active-low reset
//     lru_update  - one-hot way to touch (read hit), all-zero for none
//     add_cache   - touch the current LRU way (write insertion)
//     lru_number  - one-hot marker of the way holding the oldest age
module lru
    import victim_cache_pkg::*;
#(
    parameter int WAYS = victim_cache_pkg::WAYS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WAYS-1:0] lru_update,
    input  logic            add_cache,
    output logic [WAYS-1:0] lru_number
);

    localparam int AW = $clog2(WAYS);

    logic [AW-1:0]   age_q [WAYS];
    logic [AW-1:0]   age_d [WAYS];
    logic [WAYS-1:0] touch;
    logic            touch_any;
    logic [AW-1:0]   touch_age;

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            lru_number[i] = (age_q[i] == AW'(WAYS - 1));
        end
    end

    // Ages stay a permutation of 0..WAYS-1: only ways younger than the
    // touched one move up, so no two ways ever share an age.
    always_comb begin
        touch     = add_cache ? lru_number : lru_update;
        touch_any = |touch;
        touch_age = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (touch[i]) begin
                touch_age = touch_age | age_q[i];
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
            if (touch_any) begin
                if (touch[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
        end
    end

    // Reset leaves way 0 oldest so the first fills land in ways 0,1,2,...
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= AW'(WAYS - 1 - i);
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/victim_cache_mux.sv
// mux2_1 / mux8_1
//   Plain selectors used on the victim cache output path.
//   mux2_1 ports: sel, in0, in1 -> out (W bits each).
//   mux8_1 ports: sel[2:0], in_flat (eight W-bit slices, slice 0 in the
//                 low bits) -> out (W bits).
module mux2_1 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

module mux8_1 #(
    parameter int W = 8
) (
    input  logic [2:0]     sel,
    input  logic [8*W-1:0] in_flat,
    output logic [W-1:0]   out
);

    always_comb begin
        out = in_flat[sel*W +: W];
    end

endmodule

// File: rtl/victim_cache.sv
// victim_cache
//   Fully-associative victim cache with a four-stage pipeline:
//     C0  page_offset / data_in / write_en captured
//     C1  phys_tag_ret / tlb_miss join; lookup, insertion, LRU touch
//     C2  64-bit word of the result block selected
//     C3  byte selected; outputs valid
//   Ports:
//     clk, reset    - clock, asynchronous active-low reset
//     page_offset   - [11:6] vindex, [5:0] byte offset in the block
//     data_in       - block inserted by a write
//     write_en      - 1 insert, 0 lookup
//     phys_tag_ret  - TLB physical tag, one cycle after its page_offset
//     tlb_miss      - TLB miss flag, one cycle after its page_offset
//     byte_out      - selected byte of block_out
//     is_found      - read hit
//     block_out     - hit block on a read, evicted block on a write
module victim_cache #(
    parameter int WAYS    = victim_cache_pkg::WAYS,
    parameter int BLOCK_W = victim_cache_pkg::BLOCK_W,
    parameter int PTAG_W  = victim_cache_pkg::PTAG_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [victim_cache_pkg::OFFSET_W-1:0] page_offset,
    input  logic [BLOCK_W-1:0]                    data_in,
    input  logic                                  write_en,
    input  logic [PTAG_W-1:0]                     phys_tag_ret,
    input  logic                                  tlb_miss,
    output logic [victim_cache_pkg::BYTE_W-1:0]   byte_out,
    output logic                                  is_found,
    output logic [BLOCK_W-1:0]                    block_out
);

    import victim_cache_pkg::*;

    localparam int KEY_LEN = PTAG_W + VINDEX_W;

    // C0 -> C1
    logic [OFFSET_W-1:0]  off1_q, off1_d;
    logic [BLOCK_W-1:0]   data1_q, data1_d;
    logic                 we1_q, we1_d;

    // Way storage
    logic [WAYS-1:0]      valid_q, valid_d;
    logic [KEY_LEN-1:0]   key_q [WAYS];
    logic [KEY_LEN-1:0]   key_d [WAYS];
    logic [BLOCK_W-1:0]   blk_q [WAYS];
    logic [BLOCK_W-1:0]   blk_d [WAYS];

    // C1 -> C2
    logic [BLOCK_W-1:0]   block2_q, block2_d;
    logic                 found2_q, found2_d;
    logic [BLK_OFF_W-1:0] off2_q, off2_d;

    // C2 -> C3
    logic [BLOCK_W-1:0]   block3_q, block3_d;
    logic                 found3_q, found3_d;
    logic [WORD_W-1:0]    word3_q, word3_d;
    logic [SEL_W-1:0]     bsel3_q, bsel3_d;

    // C1 lookup
    logic [KEY_LEN-1:0]   lookup_key;
    logic [WAYS-1:0]      match;
    logic [WAYS-1:0]      hit_onehot;
    logic                 hit_any;
    logic                 read_hit;
    logic [BLOCK_W-1:0]   hit_block;
    logic [BLOCK_W-1:0]   read_block;
    logic [BLOCK_W-1:0]   evict_block;
    logic [BLOCK_W-1:0]   stage1_block;
    logic [WAYS-1:0]      lru_update;
    logic [WAYS-1:0]      lru_number;
    logic [WORD_W-1:0]    sel_word;

    lru #(
        .WAYS (WAYS)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .lru_update (lru_update),
        .add_cache  (we1_q),
        .lru_number (lru_number)
    );

    // Lowest matching way wins so duplicate keys resolve deterministically.
    // A write ignores tlb_miss entirely; a read under tlb_miss is a no-op.
    always_comb begin
        lookup_key  = {phys_tag_ret, off1_q[VINDEX_LSB +: VINDEX_W]};
        match       = '0;
        hit_onehot  = '0;
        hit_any     = 1'b0;
        hit_block   = '0;
        evict_block = '0;
        for (int i = 0; i < WAYS; i++) begin
            match[i] = valid_q[i] && (key_q[i] == lookup_key);
        end
        for (int i = 0; i < WAYS; i++) begin
            if (match[i] && !hit_any) begin
                hit_onehot[i] = 1'b1;
                hit_any       = 1'b1;
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            if (hit_onehot[i]) begin
                hit_block = hit_block | blk_q[i];
            end
            if (lru_number[i]) begin
                evict_block = evict_block | blk_q[i];
            end
        end
        read_hit   = !we1_q && !tlb_miss && hit_any;
        lru_update = read_hit ? hit_onehot : '0;
        read_block = read_hit ? hit_block : '0;
    end

    mux2_1 #(
        .W (BLOCK_W)
    ) u_block_sel (
        .sel (we1_q),
        .in0 (read_block),
        .in1 (evict_block),
        .out (stage1_block)
    );

    // Insertion replaces the LRU way at the end of C1; a never-written way
    // still holds its reset zeros, which become the evicted block.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        blk_d   = blk_q;
        if (we1_q) begin
            for (int i = 0; i < WAYS; i++) begin
                if (lru_number[i]) begin
                    valid_d[i] = 1'b1;
                    key_d[i]   = lookup_key;
                    blk_d[i]   = data1_q;
                end
            end
        end
    end

    mux8_1 #(
        .W (WORD_W)
    ) u_word_sel (
        .sel     (off2_q[WORD_SEL_LSB +: SEL_W]),
        .in_flat (block2_q),
        .out     (sel_word)
    );

    always_comb begin
        off1_d   = page_offset;
        data1_d  = data_in;
        we1_d    = write_en;
        block2_d = stage1_block;
        found2_d = read_hit;
        off2_d   = off1_q[BLK_OFF_W-1:0];
        block3_d = block2_q;
        found3_d = found2_q;
        word3_d  = sel_word;
        bsel3_d  = off2_q[BYTE_SEL_LSB +: SEL_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off1_q   <= '0;
            data1_q  <= '0;
            we1_q    <= 1'b0;
            valid_q  <= '0;
            for (int i = 0; i < WAYS; i++) begin
                key_q[i] <= '0;
                blk_q[i] <= '0;
            end
            block2_q <= '0;
            found2_q <= 1'b0;
            off2_q   <= '0;
            block3_q <= '0;
            found3_q <= 1'b0;
            word3_q  <= '0;
            bsel3_q  <= '0;
        end else begin
            off1_q   <= off1_d;
            data1_q  <= data1_d;
            we1_q    <= we1_d;
            valid_q  <= valid_d;
            for (int i = 0; i < WAYS; i++) begin
                key_q[i] <= key_d[i];
                blk_q[i] <= blk_d[i];
            end
            block2_q <= block2_d;
            found2_q <= found2_d;
            off2_q   <= off2_d;
            block3_q <= block3_d;
            found3_q <= found3_d;
            word3_q  <= word3_d;
            bsel3_q  <= bsel3_d;
        end
    end

    mux8_1 #(
        .W (BYTE_W)
    ) u_byte_sel (
        .sel     (bsel3_q),
        .in_flat (word3_q),
        .out     (byte_out)
    );

    assign is_found  = found3_q;
    assign block_out = block3_q;

endmodule

// File: tb/tb_victim_cache.sv
// tb_victim_cache
//   Drives the victim cache as a stream of operations (C0 fields, then tag
//   and TLB flag one cycle later) and compares every result three edges
//   after issue against a sequential model: an array of ways plus a
//   recency list whose tail is the least recently used way.
module tb_victim_cache;

    import victim_cache_pkg::*;

    localparam int MAXOPS = 400;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  page_offset;
    logic [511:0] data_in;
    logic         write_en;
    logic [43:0]  phys_tag_ret;
    logic         tlb_miss;
    logic [7:0]   byte_out;
    logic         is_found;
    logic [511:0] block_out;

    int checks;
    int errors;

    victim_cache dut (
        .clk          (clk),
        .reset        (reset),
        .page_offset  (page_offset),
        .data_in      (data_in),
        .write_en     (write_en),
        .phys_tag_ret (phys_tag_ret),
        .tlb_miss     (tlb_miss),
        .byte_out     (byte_out),
        .is_found     (is_found),
        .block_out    (block_out)
    );

    always #5 clk = ~clk;

    // Operation batch and its expected / observed results
    logic         op_we    [MAXOPS];
    logic [11:0]  op_off   [MAXOPS];
    logic [511:0] op_data  [MAXOPS];
    logic [43:0]  op_tag   [MAXOPS];
    logic         op_miss  [MAXOPS];
    logic         exp_found[MAXOPS];
    logic [7:0]   exp_byte [MAXOPS];
    logic [511:0] exp_block[MAXOPS];
    logic         got_found[MAXOPS];
    logic [7:0]   got_byte [MAXOPS];
    logic [511:0] got_block[MAXOPS];
    int           n_ops;

    // Reference model
    logic             m_valid[8];
    logic [KEY_W-1:0] m_key  [8];
    logic [511:0]     m_blk  [8];
    int               m_order[$];

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_blk[i]   = '0;
        end
        m_order = {};
        for (int i = 7; i >= 0; i--) m_order.push_back(i);
    endtask

    task automatic model_touch(input int w);
        for (int i = 0; i < m_order.size(); i++) begin
            if (m_order[i] == w) begin
                m_order.delete(i);
                break;
            end
        end
        m_order.push_front(w);
    endtask

    task automatic add_op(input logic we, input logic [11:0] off, input logic [511:0] data,
                          input logic [43:0] tag, input logic miss);
        logic [KEY_W-1:0] k;
        logic [511:0]     b;
        logic [511:0]     sh;
        logic             f;
        int               v;
        k = {tag, off[11:6]};
        b = '0;
        f = 1'b0;
        v = 0;
        if (we) begin
            v = m_order[$];
            b = m_blk[v];
            m_blk[v]   = data;
            m_key[v]   = k;
            m_valid[v] = 1'b1;
            model_touch(v);
        end else if (!miss) begin
            for (int i = 0; i < 8; i++) begin
                if (!f && m_valid[i] && m_key[i] == k) begin
                    f = 1'b1;
                    v = i;
                end
            end
            if (f) begin
                b = m_blk[v];
                model_touch(v);
            end
        end
        sh = b >> (8 * int'(off[5:0]));
        op_we[n_ops]     = we;
        op_off[n_ops]    = off;
        op_data[n_ops]   = data;
        op_tag[n_ops]    = tag;
        op_miss[n_ops]   = miss;
        exp_found[n_ops] = f;
        exp_block[n_ops] = b;
        exp_byte[n_ops]  = sh[7:0];
        n_ops++;
    endtask

    // Idle slots are reads under a TLB miss, which leave all state alone.
    task automatic run_batch();
        for (int k = 0; k < n_ops + 3; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                got_found[k-3] = is_found;
                got_byte[k-3]  = byte_out;
                got_block[k-3] = block_out;
            end
            if (k < n_ops) begin
                page_offset = op_off[k];
                data_in     = op_data[k];
                write_en    = op_we[k];
            end else begin
                page_offset = '0;
                data_in     = '0;
                write_en    = 1'b0;
            end
            if (k >= 1 && k - 1 < n_ops) begin
                phys_tag_ret = op_tag[k-1];
                tlb_miss     = op_miss[k-1];
            end else begin
                phys_tag_ret = '0;
                tlb_miss     = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        write_en     = 1'b0;
        tlb_miss     = 1'b1;
        page_offset  = '0;
        data_in      = '0;
        phys_tag_ret = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [511:0] d;
        repeat (2) @(negedge clk);
        checks++;
        if (is_found !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_found got %0b want 0", is_found);
        end
        checks++;
        if (byte_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_byte got %02h want 00", byte_out);
        end
        checks++;
        if (block_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_block got %0h want 0", block_out);
        end
        reset = 1'b1;

        d = rand_block();
        n_ops = 0;
        add_op(1'b1, 12'h0C5, d, 44'h123, 1'b0);
        add_op(1'b0, 12'h0C5, '0, 44'h123, 1'b0);
        run_batch();
        checks++;
        if (got_found[1] !== 1'b1 || got_block[1] !== d) begin
            errors++;
            $display("[TB] FAIL pre_reset_hit found %0b block %0h want 1 %0h", got_found[1], got_block[1], d);
        end

        // Outputs still show the hit here; an asynchronous reset must clear
        // them before the next clock edge.
        #1 reset = 1'b0;
        #1;
        checks++;
        if (is_found !== 1'b0 || byte_out !== 8'h00 || block_out !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset found %0b byte %02h block %0h want 0 00 0", is_found, byte_out, block_out);
        end
        model_reset();
        write_en = 1'b0;
        tlb_miss = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Write caught in C1 by reset must never land.
        @(negedge clk);
        page_offset = 12'h3C0;
        data_in     = rand_block();
        write_en    = 1'b1;
        @(negedge clk);
        page_offset  = '0;
        data_in      = '0;
        write_en     = 1'b0;
        phys_tag_ret = 44'h777;
        tlb_miss     = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        tlb_miss = 1'b1;
        @(negedge clk);
        reset = 1'b1;

        n_ops = 0;
        add_op(1'b0, 12'h3C0, '0, 44'h777, 1'b0);
        add_op(1'b0, 12'h0C5, '0, 44'h123, 1'b0);
        run_batch();
        for (int j = 0; j < n_ops; j++) begin
            checks++;
            if (got_found[j] !== exp_found[j] || got_byte[j] !== exp_byte[j] || got_block[j] !== exp_block[j]) begin
                errors++;
                $display("[TB] FAIL reset_discard op%0d found %0b/%0b byte %02h/%02h block %0h want %0h",
                         j, got_found[j], exp_found[j], got_byte[j], exp_byte[j], got_block[j], exp_block[j]);
            end
        end
    endtask

    task automatic test_basic_rw();
        do_reset();
        n_ops = 0;
        add_op(1'b1, 12'h000, 512'hAAA, 44'hA, 1'b0);
        add_op(1'b0, 12'h000, '0, 44'hA, 1'b0);
        add_op(1'b0, 12'h001, '0, 44'hA, 1'b0);
        add_op(1'b0, 12'h000, '0, 44'hA, 1'b1);
        add_op(1'b0, 12'h000, '0, 44'hA, 1'b0);
        run_batch();
        for (int j = 0; j < n_ops; j++) begin
            checks++;
            if (got_found[j] !== exp_found[j] || got_byte[j] !== exp_byte[j] || got_block[j] !== exp_block[j]) begin
                errors++;
                $display("[TB] FAIL basic_rw op%0d found %0b/%0b byte %02h/%02h block %0h want %0h",
                         j, got_found[j], exp_found[j], got_byte[j], exp_byte[j], got_block[j], exp_block[j]);
            end
        end
        checks++;
        if (got_found[0] !== 1'b0 || got_block[0] !== '0) begin
            errors++;
            $display("[TB] FAIL first_write found %0b block %0h want 0 0", got_found[0], got_block[0]);
        end
        checks++;
        if (got_found[1] !== 1'b1 || got_byte[1] !== 8'hAA || got_block[1] !== 512'hAAA) begin
            errors++;
            $display("[TB] FAIL read_hit found %0b byte %02h block %0h want 1 AA AAA", got_found[1], got_byte[1], got_block[1]);
        end
        checks++;
        if (got_byte[2] !== 8'h0A) begin
            errors++;
            $display("[TB] FAIL byte_sel got %02h want 0A", got_byte[2]);
        end
        checks++;
        if (got_found[3] !== 1'b0 || got_byte[3] !== 8'h00 || got_block[3] !== '0) begin
            errors++;
            $display("[TB] FAIL tlb_miss_read found %0b byte %02h block %0h want 0 00 0", got_found[3], got_byte[3], got_block[3]);
        end
        checks++;
        if (got_found[4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reread_hit got %0b want 1", got_found[4]);
        end
    endtask

    task automatic test_lru_fill();
        do_reset();
        n_ops = 0;
        for (int t = 1; t <= 9; t++) begin
            add_op(1'b1, 12'h000, 512'(t * 17), 44'(t), 1'b0);
        end
        add_op(1'b0, 12'h000, '0, 44'h1, 1'b0);
        add_op(1'b0, 12'h000, '0, 44'h9, 1'b0);
        run_batch();
        for (int j = 0; j < n_ops; j++) begin
            checks++;
            if (got_found[j] !== exp_found[j] || got_byte[j] !== exp_byte[j] || got_block[j] !== exp_block[j]) begin
                errors++;
                $display("[TB] FAIL lru_fill op%0d found %0b/%0b byte %02h/%02h block %0h want %0h",
                         j, got_found[j], exp_found[j], got_byte[j], exp_byte[j], got_block[j], exp_block[j]);
            end
        end
        checks++;
        if (got_block[8] !== 512'h11) begin
            errors++;
            $display("[TB] FAIL ninth_evict got %0h want 11", got_block[8]);
        end
        checks++;
        if (got_found[9] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL evicted_miss got %0b want 0", got_found[9]);
        end
        checks++;
        if (got_found[10] !== 1'b1 || got_block[10] !== 512'h99) begin
            errors++;
            $display("[TB] FAIL newest_hit found %0b block %0h want 1 99", got_found[10], got_block[10]);
        end
    endtask

    task automatic test_dup_and_tlb_write();
        logic [511:0] d1;
        logic [511:0] d2;
        logic [511:0] d3;
        d1 = rand_block();
        d2 = rand_block();
        d3 = rand_block();
        do_reset();
        n_ops = 0;
        add_op(1'b1, 12'h2A8, d1, 44'h3F, 1'b0);
        add_op(1'b1, 12'h2A8, d2, 44'h3F, 1'b1);
        add_op(1'b0, 12'h2A8, '0, 44'h3F, 1'b0);
        add_op(1'b1, 12'h100, d3, 44'h40, 1'b1);
        add_op(1'b0, 12'h100, '0, 44'h40, 1'b0);
        run_batch();
        for (int j = 0; j < n_ops; j++) begin
            checks++;
            if (got_found[j] !== exp_found[j] || got_byte[j] !== exp_byte[j] || got_block[j] !== exp_block[j]) begin
                errors++;
                $display("[TB] FAIL dup_key op%0d found %0b/%0b byte %02h/%02h block %0h want %0h",
                         j, got_found[j], exp_found[j], got_byte[j], exp_byte[j], got_block[j], exp_block[j]);
            end
        end
        checks++;
        if (got_found[2] !== 1'b1 || got_block[2] !== d1) begin
            errors++;
            $display("[TB] FAIL dup_priority found %0b block %0h want 1 %0h", got_found[2], got_block[2], d1);
        end
        checks++;
        if (got_found[4] !== 1'b1 || got_block[4] !== d3) begin
            errors++;
            $display("[TB] FAIL tlb_miss_write found %0b block %0h want 1 %0h", got_found[4], got_block[4], d3);
        end
    endtask

    task automatic test_random();
        n_ops = 0;
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic        miss;
            logic [11:0] off;
            we   = ($urandom_range(0, 99) < 35);
            miss = ($urandom_range(0, 99) < 15);
            off  = {6'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
            add_op(we, off, rand_block(), 44'($urandom_range(1, 4)), miss);
        end
        run_batch();
        for (int j = 0; j < n_ops; j++) begin
            checks++;
            if (got_found[j] !== exp_found[j] || got_byte[j] !== exp_byte[j] || got_block[j] !== exp_block[j]) begin
                errors++;
                $display("[TB] FAIL random op%0d found %0b/%0b byte %02h/%02h block %0h want %0h",
                         j, got_found[j], exp_found[j], got_byte[j], exp_byte[j], got_block[j], exp_block[j]);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        n_ops        = 0;
        reset        = 1'b0;
        write_en     = 1'b0;
        tlb_miss     = 1'b1;
        page_offset  = '0;
        data_in      = '0;
        phys_tag_ret = '0;
        model_reset();
        test_reset();
        test_basic_rw();
        test_lru_fill();
        test_dup_and_tlb_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/victim_cache.md
VICTIM_CACHE -- requirements
Module: victim_cache

Interface
REQ-001 The parameters SHALL be, one per line:
- WAYS, 8, number of fully-associative entries.
- BLOCK_W, 512, block width in bits.
- PTAG_W, 44, physical tag width.
REQ-002 The ports SHALL be, one per line:
- clk, input, 1, the single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- page_offset, input, 12, bits [11:6] are the vindex; bits [5:0] are the byte offset in the block.
- data_in, input, 512, block to insert on a write.
- write_en, input, 1, 1 = write (insert) operation, 0 = read.
- phys_tag_ret, input, 44, physical tag from the TLB; arrives one cycle after its page_offset.
- tlb_miss, input, 1, TLB miss flag; arrives one cycle after its page_offset.
- byte_out, output, 8, selected byte.
- is_found, output, 1, read hit flag.
- block_out, output, 512, hit block on a read, evicted block on a write.

Function
REQ-003 The block SHALL be a 4-stage pipeline accepting one operation per cycle.
- C0: page_offset, data_in and write_en are registered.
- C1: phys_tag_ret and tlb_miss are used with the registered C0 values.
- Outputs for the operation SHALL be valid in C3, three rising edges after C0.
REQ-004 In C1 the lookup key SHALL be {phys_tag_ret, vindex} (50 bits). Each way holds a valid bit, a 50-bit key and a 512-bit block.
REQ-005 A way SHALL hit when its valid bit is 1 and its key equals the lookup key. If several ways hit, the lowest index SHALL win.
REQ-006 Read (write_en=0, tlb_miss=0):
- The hit way's block SHALL be forwarded and the LRU SHALL touch the hit way.
- On no hit: is_found=0, block_out=0, byte_out=0x00, LRU unchanged.
REQ-007 Read with tlb_miss=1 SHALL produce is_found=0, block_out=0 and byte_out=0x00, and SHALL change no state.
REQ-008 Write (write_en=1) SHALL ignore tlb_miss, treating it as 0.
- At the end of C1, the current LRU way SHALL be loaded with key, data_in and valid=1, and the LRU SHALL touch that way.
- The way's pre-write block SHALL be forwarded as the evicted block: 0 if the way was never written.
- For a write, is_found SHALL be 0 and byte_out SHALL be the byte of the evicted block selected by the offset.
REQ-009 Writing a key already present SHALL NOT be checked. It creates a second valid entry, and REQ-005 priority applies.
REQ-010 In C2, word w = block[64w+63:64w] SHALL be selected with w = offset[5:3] and registered. In C3, byte b = word[8b+7:8b] SHALL be selected with b = offset[2:0].
REQ-011 A write in cycle N SHALL be visible to a read whose C1 is cycle N+1 or later, with no bypass needed.
REQ-012 The LRU SHALL be true LRU using one 3-bit age per way, with a one-hot LRU output marking the way of age 7.
- On a touch of way k: every way with age < age[k] increments and age[k] becomes 0.
REQ-013 After reset, the ages SHALL make way 0 the LRU, so successive writes fill ways 0,1,…,7 in order.

Reset
REQ-014 The active-low reset SHALL be asynchronous and SHALL clear:
- all pipeline registers;
- all valid bits, keys and blocks to 0;
- the LRU ages to way i = 7−i.
REQ-015 During and after reset, the outputs SHALL be is_found=0, byte_out=0x00 and block_out=0. An operation in flight when reset asserts SHALL be discarded.

Structure
REQ-016 A shared package SHALL hold WAYS, BLOCK_W, PTAG_W, KEY_W=50 and the offset field positions.
REQ-017 The LRU SHALL be a sub-module named lru with ports:
- clk, reset;
- lru_update: 8-bit one-hot hit;
- add_cache: write touch of the LRU way;
- lru_number: 8-bit one-hot LRU output.
The word/byte selection SHALL use 2:1/8:1 muxes (mux2_1, mux8_1).

Verification
REQ-018 Reset asserted: is_found=0, byte_out=0x00, block_out=0.
REQ-019 After reset, write page_offset 0x000, data_in 0xAAA, phys_tag 0xA: at C3, is_found=0, block_out=0 (way 0 evicted, empty).
REQ-020 Then read page_offset 0x000, tag 0xA → is_found=1, byte_out=0xAA, block_out=0xAAA; read page_offset 0x001 → byte_out=0x0A.
REQ-021 Read tag 0xA with tlb_miss=1 → is_found=0, byte_out=0x00, block_out=0; a later read of the same address with tlb_miss=0 still hits.
REQ-022 Write 9 distinct tags 0x1–0x9 with data 0x11…0x99:
- the 9th write returns block_out=0x11;
- a subsequent read of tag 0x1 misses;
- a read of tag 0x9 hits.
REQ-023 A write with tlb_miss=1 still inserts, and a following read of that key hits.
